// File: rtl/mux_scan_sequencer_if.sv
// Output word handshake of the mux scan sequencer.
// The sequencer drives the word and its valid flag. The consumer drives ready.
interface mux_scan_sequencer_if;
    logic [3:0] data_out;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output data_out,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  data_out,
        input  out_valid,
        output out_ready
    );
endinterface : mux_scan_sequencer_if

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps a 4:1 mux select through channels 0..3.
// Each select value is held for DWELL cycles, then the mux output y_in is sampled.
// The four samples are packed into one word, which is offered on a valid/ready handshake.
// Continuous mode rescans with no idle cycle between scans.
module mux_scan_sequencer #(
    parameter int DWELL = 2,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   cont,
    input  logic                   abort,
    input  logic                   y_in,
    output logic                   s1,
    output logic                   s0,
    output logic                   busy,
    mux_scan_sequencer_if.master   out_if
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Last dwell count before the current channel is sampled.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_t            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        shadow_q, shadow_d;
    logic [3:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= 2'b00;
            cnt_q    <= '0;
            shadow_q <= 3'b000;
            data_q   <= 4'b0000;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic: dwell counting, per-channel sampling and the output handshake.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = valid_q;
        busy_d   = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SCAN;
                    sel_d   = 2'b00;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    sel_d   = 2'b00;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                end
            end

            ST_SCAN: begin
                if (abort) begin
                    // Abort wins over sampling. The previous data_out stays visible.
                    state_d  = ST_IDLE;
                    sel_d    = 2'b00;
                    cnt_d    = '0;
                    shadow_d = 3'b000;
                    busy_d   = 1'b0;
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                    case (sel_q)
                        2'd0: begin
                            shadow_d[0] = y_in;
                            sel_d       = 2'd1;
                        end
                        2'd1: begin
                            shadow_d[1] = y_in;
                            sel_d       = 2'd2;
                        end
                        2'd2: begin
                            shadow_d[2] = y_in;
                            sel_d       = 2'd3;
                        end
                        default: begin
                            // Channel 3 goes straight into the word with the three shadowed bits.
                            data_d  = {y_in, shadow_q};
                            valid_d = 1'b1;
                            busy_d  = 1'b0;
                            sel_d   = 2'b00;
                            state_d = ST_OUT;
                        end
                    endcase
                end
            end

            ST_OUT: begin
                if (valid_q && out_if.out_ready) begin
                    valid_d = 1'b0;
                    if (cont) begin
                        // Start the next scan on the accept edge so there is no idle cycle.
                        state_d = ST_SCAN;
                        sel_d   = 2'b00;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    // Hold the word. start and abort have no effect here.
                    sel_d = 2'b00;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                sel_d    = 2'b00;
                cnt_d    = '0;
                shadow_d = 3'b000;
                valid_d  = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    assign s1               = sel_q[1];
    assign s0               = sel_q[0];
    assign busy             = busy_q;
    assign out_if.data_out  = data_q;
    assign out_if.out_valid = valid_q;

endmodule : mux_scan_sequencer

// File: tb/tb_mux_scan_sequencer.sv
// Testbench for mux_scan_sequencer.
// Expected words go into queues when a scan is launched.
// Monitors pop and compare each accepted word.
// Timing, select and state checks are made inline.
module tb_mux_scan_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Instance with DWELL=2.
    logic       start2 = 1'b0, cont2 = 1'b0, abort2 = 1'b0;
    logic       s1_2, s0_2, busy2, y2;
    logic [3:0] mux2_i = 4'b0000;
    mux_scan_sequencer_if bus2 ();

    // Instance with DWELL=1.
    logic       start1 = 1'b0;
    logic       cont1 = 1'b0;
    logic       abort1 = 1'b0;
    logic       s1_1, s0_1, busy1, y1;
    logic [3:0] mux1_i = 4'b0000;
    mux_scan_sequencer_if bus1 ();

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] exp2_q[$];
    logic [3:0] exp1_q[$];

    always #5 clk = ~clk;

    // Behavioural 4:1 mux models.
    assign y2 = mux2_i[{s1_2, s0_2}];
    assign y1 = mux1_i[{s1_1, s0_1}];

    mux_scan_sequencer #(.DWELL(2), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .cont(cont2), .abort(abort2),
        .y_in(y2), .s1(s1_2), .s0(s0_2), .busy(busy2), .out_if(bus2)
    );

    mux_scan_sequencer #(.DWELL(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .cont(cont1), .abort(abort1),
        .y_in(y1), .s1(s1_1), .s0(s0_1), .busy(busy1), .out_if(bus1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int t = 0; t < n; t++) tick();
    endtask

    // Scoreboard monitor for the DWELL=2 instance. A transfer happens on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus2.out_valid && bus2.out_ready) begin
            if (exp2_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL word2: unexpected word %b", bus2.data_out);
            end else begin
                chk("word2", {28'd0, bus2.data_out}, {28'd0, exp2_q.pop_front()});
            end
        end
    end

    // Scoreboard monitor for the DWELL=1 instance.
    always @(negedge clk) begin
        if (rst_n && bus1.out_valid && bus1.out_ready) begin
            if (exp1_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL word1: unexpected word %b", bus1.data_out);
            end else begin
                chk("word1", {28'd0, bus1.data_out}, {28'd0, exp1_q.pop_front()});
            end
        end
    end

    initial begin
        bus2.out_ready = 1'b0;
        bus1.out_ready = 1'b0;

        // Reset state.
        ticks(2);
        chk("rst_sel", {30'd0, s1_2, s0_2}, 32'd0);
        chk("rst_busy", {31'd0, busy2}, 32'd0);
        chk("rst_valid", {31'd0, bus2.out_valid}, 32'd0);
        chk("rst_data", {28'd0, bus2.data_out}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single shot, i=1010.
        mux2_i = 4'b1010;
        exp2_q.push_back(4'b1010);
        start2 = 1'b1;
        tick();                                 // edge k
        start2 = 1'b0;
        chk("ss_busy", {31'd0, busy2}, 32'd1);
        for (int m = 0; m < 8; m++) begin
            chk("ss_sel", {30'd0, s1_2, s0_2}, 32'(m / 2));
            chk("ss_novalid", {31'd0, bus2.out_valid}, 32'd0);
            tick();
        end
        // now after edge k+8
        chk("ss_valid", {31'd0, bus2.out_valid}, 32'd1);
        chk("ss_busy_out", {31'd0, busy2}, 32'd0);
        chk("ss_sel_out", {30'd0, s1_2, s0_2}, 32'd0);
        bus2.out_ready = 1'b1;
        tick();
        bus2.out_ready = 1'b0;
        chk("ss_valid_clr", {31'd0, bus2.out_valid}, 32'd0);
        chk("ss_idle", {31'd0, busy2}, 32'd0);

        // Backpressure, i=0110.
        mux2_i = 4'b0110;
        exp2_q.push_back(4'b0110);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        ticks(8);
        for (int c = 0; c < 5; c++) begin
            start2 = 1'b1;
            chk("bp_valid", {31'd0, bus2.out_valid}, 32'd1);
            chk("bp_data", {28'd0, bus2.data_out}, 32'h6);
            chk("bp_busy", {31'd0, busy2}, 32'd0);
            tick();
        end
        start2 = 1'b0;
        bus2.out_ready = 1'b1;
        tick();
        bus2.out_ready = 1'b0;
        chk("bp_valid_clr", {31'd0, bus2.out_valid}, 32'd0);
        tick();
        chk("bp_idle", {31'd0, busy2}, 32'd0);

        // Continuous mode: 1111, then 0001.
        mux2_i = 4'b1111;
        cont2 = 1'b1;
        exp2_q.push_back(4'b1111);
        exp2_q.push_back(4'b0001);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        ticks(8);
        chk("ct_valid1", {31'd0, bus2.out_valid}, 32'd1);
        bus2.out_ready = 1'b1;
        tick();                                 // accept, rescan at edge k'
        bus2.out_ready = 1'b0;
        chk("ct_rescan_busy", {31'd0, busy2}, 32'd1);
        chk("ct_rescan_sel", {30'd0, s1_2, s0_2}, 32'd0);
        chk("ct_rescan_valid", {31'd0, bus2.out_valid}, 32'd0);
        tick();                                 // k'+1, before channel 1 is sampled
        mux2_i = 4'b0001;
        cont2 = 1'b0;
        ticks(7);                               // k'+8
        chk("ct_valid2", {31'd0, bus2.out_valid}, 32'd1);
        chk("ct_sel2", {30'd0, s1_2, s0_2}, 32'd0);
        bus2.out_ready = 1'b1;
        tick();
        bus2.out_ready = 1'b0;
        chk("ct_end_valid", {31'd0, bus2.out_valid}, 32'd0);
        chk("ct_end_busy", {31'd0, busy2}, 32'd0);
        chk("ct_end_sel", {30'd0, s1_2, s0_2}, 32'd0);

        // Abort at cycle 3 of a scan. data_out must keep 0001.
        mux2_i = 4'b0101;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        ticks(2);
        abort2 = 1'b1;
        tick();
        abort2 = 1'b0;
        chk("ab_busy", {31'd0, busy2}, 32'd0);
        chk("ab_sel", {30'd0, s1_2, s0_2}, 32'd0);
        for (int c = 0; c < 8; c++) begin
            chk("ab_novalid", {31'd0, bus2.out_valid}, 32'd0);
            tick();
        end
        chk("ab_data_kept", {28'd0, bus2.data_out}, 32'h1);
        exp2_q.push_back(4'b0101);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        ticks(8);
        chk("ab_rescan_valid", {31'd0, bus2.out_valid}, 32'd1);
        bus2.out_ready = 1'b1;
        tick();
        bus2.out_ready = 1'b0;

        // Reset in the middle of a scan. The clear must show without a clock edge.
        mux2_i = 4'b1010;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        ticks(2);
        chk("mr_pre_busy", {31'd0, busy2}, 32'd1);
        chk("mr_pre_sel", {30'd0, s1_2, s0_2}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_sel", {30'd0, s1_2, s0_2}, 32'd0);
        chk("mr_busy", {31'd0, busy2}, 32'd0);
        chk("mr_valid", {31'd0, bus2.out_valid}, 32'd0);
        chk("mr_data", {28'd0, bus2.data_out}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mr_after_busy", {31'd0, busy2}, 32'd0);

        // DWELL=1, i=1000.
        mux1_i = 4'b1000;
        exp1_q.push_back(4'b1000);
        start1 = 1'b1;
        tick();                                 // edge k
        start1 = 1'b0;
        for (int m = 0; m < 4; m++) begin
            chk("d1_sel", {30'd0, s1_1, s0_1}, 32'(m));
            chk("d1_novalid", {31'd0, bus1.out_valid}, 32'd0);
            tick();
        end
        chk("d1_valid", {31'd0, bus1.out_valid}, 32'd1);
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        chk("d1_valid_clr", {31'd0, bus1.out_valid}, 32'd0);

        // Every queued word must have been delivered.
        ticks(2);
        chk("sb2_drained", 32'(exp2_q.size()), 32'd0);
        chk("sb1_drained", 32'(exp1_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mux_scan_sequencer
